bus_timer: RTL and testbench

- Memory-mapped countdown timer on the CPU data bus (m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata), sitting directly downstream of the processor's M stage.
- Its irq output drives one bit of the CPU's HWInt[5:0] input, which CP0 samples.
- Provides one-shot and auto-reload modes, byte-enabled register writes, and a combinational read path so M-stage loads complete in the same cycle.

---
 rtl/bus_timer.sv | 144 ++++++++++++++
 tb/tb_bus_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// ============================================================================
// bus_timer : memory-mapped countdown timer (one-shot / auto-reload) on the
//             CPU data bus. Optional STATUS register at 0xC: TIMER_STATUS_REG_EN
// Revision  : 1.0
// ============================================================================
`default_nettype none

module bus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        hit;
  logic [1:0]  sel;
  logic        ctrl_wr;
  logic        ctrl_en_wr;
  logic        preset_sel;
  logic        auto_reload;
  logic [3:0]  ctrl_next;
  logic [31:0] preset_next;
  logic        unused_addr_bits;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel         = addr[3:2];
  assign ctrl_wr     = hit && (sel == 2'd0) && (byteen != 4'b0000);
  assign ctrl_en_wr  = hit && (sel == 2'd0) && byteen[0];
  assign preset_sel  = hit && (sel == 2'd1);
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign unused_addr_bits = ^addr[1:0];

`ifdef TIMER_STATUS_REG_EN
  logic busy;
  logic status_clr;
  assign busy       = (state != S_IDLE);
  assign status_clr = hit && (sel == 2'd3) && byteen[0] && wdata[1];
`endif

  // A bus write to CTRL byte 0 overrides the one-shot EN auto-clear in INT.
  always_comb begin
    ctrl_next = ctrl;
    if (ctrl_en_wr)
      ctrl_next = wdata[3:0];
    if ((state == S_INT) && !auto_reload && !ctrl_en_wr)
      ctrl_next[0] = 1'b0;
  end

  always_comb begin
    preset_next = preset;
    for (int i = 0; i < 4; i++) begin
      if (preset_sel && byteen[i])
        preset_next[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ctrl     <= 4'b0;
      preset   <= 32'b0;
      count    <= 32'b0;
      irq_flag <= 1'b0;
    end else begin
      ctrl   <= ctrl_next;
      preset <= preset_next;

      case (state)
        S_IDLE: begin
          if (ctrl[0])
            state <= S_LOAD;
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl[0]) begin
            state <= S_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= 32'b0;
            state <= S_INT;
          end
        end
        S_INT: begin
          state <= auto_reload ? S_LOAD : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Setting in INT has priority over every clear source.
      if (state == S_INT)
        irq_flag <= 1'b1;
`ifdef TIMER_STATUS_REG_EN
      else if (ctrl_wr || auto_reload || status_clr)
`else
      else if (ctrl_wr || auto_reload)
`endif
        irq_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'b0;
    if (hit) begin
      case (sel)
        2'd0: rdata = {28'b0, ctrl};
        2'd1: rdata = preset;
        2'd2: rdata = count;
`ifdef TIMER_STATUS_REG_EN
        2'd3: rdata = {30'b0, irq_flag, busy};
`else
        2'd3: rdata = 32'b0;
`endif
        default: rdata = 32'b0;
      endcase
    end
  end

  assign irq = irq_flag & ctrl[3];

endmodule

`default_nettype wire

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer.
`default_nettype none

module tb_bus_timer;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_STATUS = 32'h0000_7F0C;
  localparam logic [31:0] A_MISS   = 32'h0000_7F10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_timer #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .byteen (byteen),
    .rdata  (rdata),
    .irq    (irq)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr   = a;
    wdata  = d;
    byteen = be;
    step();
    byteen = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic reset_dut();
    reset  = 1'b1;
    byteen = 4'b0000;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        seen;
    logic        prev;
    int          pulses[16];
    int          np;
    int          dbl;
    int          in_win;

    addr   = 32'b0;
    wdata  = 32'b0;
    byteen = 4'b0;
    reset  = 1'b0;

    // Reset state
    reset_dut();
    bus_read(A_CTRL, d);   check_value("rst_ctrl", d, 32'h0);
    bus_read(A_PRESET, d); check_value("rst_preset", d, 32'h0);
    bus_read(A_COUNT, d);  check_value("rst_count", d, 32'h0);
    check_value("rst_irq", {31'b0, irq}, 32'h0);
    bus_read(A_MISS, d);   check_value("miss_read", d, 32'h0);

    // One-shot, PRESET=5, IM=1
    bus_write(A_PRESET, 32'd5, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'h1);
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      bus_read(A_COUNT, d);
      check_value("oneshot_count", d, 32'(5 - i));
      if (i == 5) check_value("oneshot_irq_in_int", {31'b0, irq}, 32'h0);
      step();
    end
    check_value("oneshot_irq_rise", {31'b0, irq}, 32'h1);
    bus_read(A_CTRL, d); check_value("oneshot_en_cleared", d, 32'h8);
    step(); step(); step();
    check_value("oneshot_irq_held", {31'b0, irq}, 32'h1);
    bus_read(A_COUNT, d); check_value("oneshot_count_hold", d, 32'h0);
    bus_write(A_CTRL, 32'h0, 4'h1);
    check_value("oneshot_irq_cleared", {31'b0, irq}, 32'h0);

    // Byte enables, COUNT read-only, CTRL upper bits, miss writes
    reset_dut();
    bus_write(A_PRESET, 32'hAABBCCDD, 4'b0010);
    bus_read(A_PRESET, d); check_value("byteen_preset", d, 32'h0000CC00);
    bus_write(A_COUNT, 32'h12345678, 4'hF);
    bus_read(A_COUNT, d); check_value("count_ro", d, 32'h0);
    bus_write(A_CTRL, 32'hFFFFFFF8, 4'hF);
    bus_read(A_CTRL, d); check_value("ctrl_upper_bits", d, 32'h8);
    bus_write(32'h0000_7F14, 32'hDEADBEEF, 4'hF);
    bus_read(A_PRESET, d); check_value("miss_write", d, 32'h0000CC00);

    // Auto-reload, PRESET=3, then PRESET=6 mid-count
    reset_dut();
    bus_write(A_PRESET, 32'd3, 4'hF);
    bus_write(A_CTRL, 32'hB, 4'h1);
    np = 0; dbl = 0; in_win = 0; prev = 1'b0;
    for (int k = 0; k < 16; k++) pulses[k] = 0;
    for (int c = 1; c <= 50; c++) begin
      if (c == 28) bus_write(A_PRESET, 32'd6, 4'hF);
      else step();
      if (irq) begin
        if (np < 16) pulses[np] = c;
        np++;
        if (c >= 6 && c <= 25) in_win++;
        if (prev) dbl++;
      end
      prev = irq;
    end
    check_value("auto_first_pulse", pulses[0], 32'd6);
    check_value("auto_pulses_20cyc", in_win, 32'd4);
    check_value("auto_pulse_width", dbl, 32'd0);
    check_value("auto_npulses", np, 32'd8);
    check_value("auto_period_before", pulses[5] - pulses[4], 32'd5);
    check_value("auto_period_after1", pulses[6] - pulses[5], 32'd8);
    check_value("auto_period_after2", pulses[7] - pulses[6], 32'd8);

    // Disable mid-count, then reset mid-count
    reset_dut();
    bus_write(A_PRESET, 32'd10, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'h1);
    step(); step(); step();
    bus_write(A_CTRL, 32'h0, 4'h1);
    step();
    bus_read(A_COUNT, d); check_value("disable_freeze", d, 32'd8);
    step(); step(); step();
    bus_read(A_COUNT, d); check_value("disable_hold", d, 32'd8);
`ifdef TIMER_STATUS_REG_EN
    bus_read(A_STATUS, d); check_value("disable_idle", d, 32'h0);
`endif
    bus_write(A_CTRL, 32'h9, 4'h1);
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    bus_read(A_CTRL, d);   check_value("midrst_ctrl", d, 32'h0);
    bus_read(A_PRESET, d); check_value("midrst_preset", d, 32'h0);
    bus_read(A_COUNT, d);  check_value("midrst_count", d, 32'h0);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      seen = seen | irq;
    end
    check_value("midrst_no_irq", {31'b0, seen}, 32'h0);
    bus_read(A_COUNT, d); check_value("midrst_count_after", d, 32'h0);

    // IM=0, one-shot, PRESET=1
    reset_dut();
    bus_write(A_PRESET, 32'd1, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'h1);
    seen = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      seen = seen | irq;
      if (c == 2) begin bus_read(A_COUNT, d); check_value("p1_count_cnt", d, 32'd1); end
      if (c == 3) begin bus_read(A_COUNT, d); check_value("p1_count_int", d, 32'd0); end
    end
    check_value("masked_irq", {31'b0, seen}, 32'h0);
    bus_read(A_CTRL, d); check_value("p1_ctrl_after", d, 32'h0);
`ifdef TIMER_STATUS_REG_EN
    bus_read(A_STATUS, d); check_value("status_expired", d, 32'h2);
    bus_write(A_STATUS, 32'h2, 4'h1);
    bus_read(A_STATUS, d); check_value("status_cleared", d, 32'h0);
`else
    bus_read(A_STATUS, d); check_value("reserved_read", d, 32'h0);
    bus_write(A_STATUS, 32'hFFFFFFFF, 4'hF);
    bus_read(A_STATUS, d); check_value("reserved_write", d, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
